// File: rtl/readout_sequencer.sv
// Channel readout sequencer: scans enabled channels, issuing load / shift-window / gap per channel.
// Optional completed-pass counter enabled with `define SEQ_FRAME_CNT_EN.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | waiting for an accepted READ_ALL / READ_ONE instruction
// S_LOAD  | one cycle, load_cnt_ser strobe for chan_sel
// S_SHIFT | SHIFT_LEN cycles of ser_shift_en
// S_GAP   | GAP_CYCLES quiet cycles, chan_sel held
// S_DONE  | one-cycle done pulse; repeats the pass when cont is set
module readout_sequencer #(
   parameter  int NUM_CH     = 8,
   parameter  int SHIFT_LEN  = 12,
   parameter  int GAP_CYCLES = 2,
   localparam int CW         = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
   input  logic              iclk,
   input  logic              rstn,
   input  logic              instr_valid,
   input  logic [7:0]        instruction,
   input  logic [NUM_CH-1:0] trigger_channel_mask,
   input  logic [7:0]        mode,
   output logic [CW-1:0]     chan_sel,
   output logic              load_cnt_ser,
   output logic              ser_shift_en,
   output logic              busy,
   output logic              done,
   output logic              cmd_rej,
   output logic [7:0]        frame_cnt
);

   localparam int CNT_W    = $clog2(SHIFT_LEN + GAP_CYCLES + 1);
   localparam int GAP_LOAD = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;

   typedef enum logic [2:0] {S_IDLE, S_LOAD, S_SHIFT, S_GAP, S_DONE} state_t;

   state_t              state, state_nxt;
   logic [CW-1:0]       chan_q, chan_nxt;
   logic [NUM_CH-1:0]   rem_q, rem_nxt;
   logic [CNT_W-1:0]    cnt_q, cnt_nxt;
   logic                cont_q, cont_nxt;
   logic                rej_q, rej_nxt;

   logic [3:0]          opcode;
   logic [NUM_CH-1:0]   one_sel;
   logic                do_snap, adv;
   logic [NUM_CH-1:0]   snap_set;
   state_t              snap_empty_state;
   logic                unused_bits;

   assign opcode      = instruction[3:0];
   assign one_sel     = NUM_CH'(1) << instruction[6:4];
   assign unused_bits = &{1'b0, instruction[7], mode[7:1]};

   function automatic logic [CW-1:0] lowest(input logic [NUM_CH-1:0] v);
      lowest = '0;
      for (int i = NUM_CH - 1; i >= 0; i--) begin
         if (v[i]) lowest = CW'(i);
      end
   endfunction

   always_ff @(posedge iclk) begin
      if (!rstn) begin
         state  <= S_IDLE;
         chan_q <= '0;
         rem_q  <= '0;
         cnt_q  <= '0;
         cont_q <= 1'b0;
         rej_q  <= 1'b0;
      end else begin
         state  <= state_nxt;
         chan_q <= chan_nxt;
         rem_q  <= rem_nxt;
         cnt_q  <= cnt_nxt;
         cont_q <= cont_nxt;
         rej_q  <= rej_nxt;
      end
   end

   always_comb begin
      state_nxt        = state;
      chan_nxt         = chan_q;
      rem_nxt          = rem_q;
      cnt_nxt          = cnt_q;
      cont_nxt         = cont_q;
      rej_nxt          = 1'b0;
      do_snap          = 1'b0;
      adv              = 1'b0;
      snap_set         = '0;
      snap_empty_state = S_IDLE;

      case (state)
         S_IDLE: begin
            if (instr_valid) begin
               case (opcode)
                  4'h0, 4'h1: ;
                  4'h2: begin
                     do_snap          = 1'b1;
                     snap_set         = trigger_channel_mask;
                     snap_empty_state = S_DONE;
                  end
                  4'h3: begin
                     do_snap          = 1'b1;
                     snap_set         = one_sel;
                     snap_empty_state = S_DONE;
                  end
                  default: rej_nxt = 1'b1;
               endcase
            end
         end
         S_LOAD: begin
            rem_nxt   = rem_q & ~(NUM_CH'(1) << chan_q);
            cnt_nxt   = CNT_W'(SHIFT_LEN - 1);
            state_nxt = S_SHIFT;
         end
         S_SHIFT: begin
            if (cnt_q == '0) begin
               if (GAP_CYCLES > 0) begin
                  state_nxt = S_GAP;
                  cnt_nxt   = CNT_W'(GAP_LOAD);
               end else begin
                  adv = 1'b1;
               end
            end else begin
               cnt_nxt = cnt_q - 1'b1;
            end
         end
         S_GAP: begin
            if (cnt_q == '0) adv = 1'b1;
            else             cnt_nxt = cnt_q - 1'b1;
         end
         S_DONE: begin
            if (cont_q) begin
               do_snap          = 1'b1;
               snap_set         = trigger_channel_mask;
               snap_empty_state = S_IDLE;
            end else begin
               state_nxt = S_IDLE;
            end
         end
         default: state_nxt = S_IDLE;
      endcase

      // remaining set already excludes the channel just visited
      if (adv) begin
         if (|rem_q) begin
            state_nxt = S_LOAD;
            chan_nxt  = lowest(rem_q);
         end else begin
            state_nxt = S_DONE;
         end
      end

      if (do_snap) begin
         cont_nxt = mode[0];
         rem_nxt  = snap_set;
         if (|snap_set) begin
            state_nxt = S_LOAD;
            chan_nxt  = lowest(snap_set);
         end else begin
            state_nxt = snap_empty_state;
         end
      end

      if (state != S_IDLE && instr_valid) begin
         if (opcode == 4'h1)      state_nxt = S_IDLE;
         else if (opcode != 4'h0) rej_nxt   = 1'b1;
      end
   end

   assign chan_sel     = chan_q;
   assign load_cnt_ser = (state == S_LOAD);
   assign ser_shift_en = (state == S_SHIFT);
   assign busy         = (state == S_LOAD) || (state == S_SHIFT) || (state == S_GAP);
   assign done         = (state == S_DONE);
   assign cmd_rej      = rej_q;

`ifdef SEQ_FRAME_CNT_EN
   logic [7:0] frame_q;

   always_ff @(posedge iclk) begin
      if (!rstn)                frame_q <= '0;
      else if (state == S_DONE) frame_q <= frame_q + 8'd1;
   end

   assign frame_cnt = frame_q;
`else
   assign frame_cnt = '0;
`endif

endmodule

// File: doc/readout_sequencer.md
Name: readout_sequencer

Overview:
Sequences channel readout in the PSEC5 digital core after the SPI slave has delivered an instruction. Consumes the SPI-written `instruction`, `trigger_channel_mask` and `mode` registers. Scans the enabled channels, driving channel select, a one-cycle counter-load strobe and a shift-enable window for the serializer. Runs on `iclk`.

Parameters:
NUM_CH, 8, number of channels; width of the mask; chan_sel width is clog2(NUM_CH)
SHIFT_LEN, 12, ser_shift_en cycles per channel (counter bits serialized)
GAP_CYCLES, 2, idle cycles after each shift window before the next channel

Ports:
iclk  input  1  internal clock; all logic on posedge
rstn  input  1  synchronous active-low reset, sampled on posedge iclk
instr_valid  input  1  one-cycle pulse: instruction register was just written
instruction  input  8  [3:0] opcode, [6:4] channel for READ_ONE, [7] reserved
trigger_channel_mask  input  NUM_CH  channel enable mask
mode  input  8  [0] continuous repeat; [7:1] ignored
chan_sel  output  3  channel currently addressed
load_cnt_ser  output  1  one-cycle strobe: load the counter of chan_sel into the serializer
ser_shift_en  output  1  serializer shift enable
busy  output  1  sequence in progress
done  output  1  one-cycle pulse at end of each pass
cmd_rej  output  1  one-cycle pulse: command ignored
frame_cnt  output  8  completed-pass counter (see Optional Feature)

Behaviour:
- Reset (rstn=0 at posedge): state IDLE. chan_sel=0, load_cnt_ser=0, ser_shift_en=0, busy=0, done=0, cmd_rej=0, frame_cnt=0. Reset mid-sequence aborts at that edge; no further strobes.
- Opcodes:
  - 0x0 NOP.
  - 0x1 ABORT.
  - 0x2 READ_ALL: scan the mask.
  - 0x3 READ_ONE: channel instruction[6:4].
  - Other opcodes: cmd_rej pulse, no state change.
- Command accept happens only in IDLE when instr_valid=1.
  - Snapshot: active set (mask, or the single channel for READ_ONE) and cont=mode[0].
  - Later writes to the mask or mode do not affect the current pass.
- States: IDLE, LOAD, SHIFT, GAP, DONE.
  - IDLE -> LOAD on accept when the active set is non-empty; chan_sel = lowest set bit.
  - READ_ALL with mask=0: IDLE -> DONE directly. No LOAD, no shift; done pulses the cycle after accept.
  - LOAD: 1 cycle, load_cnt_ser=1, then -> SHIFT.
  - SHIFT: exactly SHIFT_LEN cycles with ser_shift_en=1, then -> GAP.
  - GAP: GAP_CYCLES cycles with both strobes low, chan_sel held. GAP_CYCLES=0 skips GAP.
  - After GAP: -> LOAD with chan_sel = next higher set bit; if none remain -> DONE.
  - DONE: 1 cycle, done=1.
  - From DONE: -> IDLE if cont=0. If cont=1, re-snapshot mask and mode[0] and -> LOAD at the lowest set bit. If the new mask is empty, -> IDLE.
- Channel timing: each channel costs 1+SHIFT_LEN+GAP_CYCLES cycles. chan_sel is stable from LOAD through the end of GAP.
- busy=1 in LOAD, SHIFT and GAP; busy=0 in IDLE and DONE.
- instr_valid while not IDLE:
  - ABORT: next state IDLE, all strobes low next cycle, no done.
  - NOP: no effect.
  - Any other opcode: cmd_rej pulse, sequence continues.
- ABORT or NOP in IDLE: no effect, no cmd_rej.
- Counters saturate at their terminal count and never wrap during a pass. Channel search is combinational priority over the remaining-set register; each visited bit is cleared at LOAD.

Optional Feature:
SEQ_FRAME_CNT_EN
- Defined: frame_cnt increments by 1 on every done pulse, wraps 255 -> 0, and clears only on reset.
- Undefined: frame_cnt tied to 0 and no counter flops are built.

Test Plan:
1. READ_ALL, mask=0x05, mode=0, accept at cycle 0 -> LOAD chan0 at cycle 1; shift 2-13; gap 14-15; LOAD chan2 at cycle 16; shift 17-28; gap 29-30; done at 31; busy low at 31; IDLE at 32.
2. READ_ONE with instruction=0x53 -> single LOAD with chan_sel=5 at cycle 1, 12 shift cycles, done at cycle 16; mask value ignored.
3. READ_ALL, mask=0x00 -> no load_cnt_ser or ser_shift_en; done at cycle 1; busy never high.
4. READ_ALL, mask=0x80, mode=1; ABORT at cycle 40 -> done pulses at cycles 16 and 32; LOADs at cycles 1, 17, 33; all strobes low from cycle 41; no further done.
5. Opcode 0x2 issued at cycle 5 of a running pass, then opcode 0xF in IDLE -> cmd_rej pulses at cycles 6 and after the 0xF write; the original pass completes unchanged.
6. rstn=0 during SHIFT -> next edge all outputs at reset values. With SEQ_FRAME_CNT_EN, frame_cnt returns to 0, then reads 1 after the next completed pass.
